// File: rtl/bus_read_sequencer.sv
// bus_read_sequencer: sequences the active-low output enables of up to NCHIP
// tri-state buffer chips sharing one 8-bit bus. Each chip is enabled alone
// for SETTLE cycles, its byte is captured on the last of those edges, and a
// one-cycle all-high turnaround separates consecutive chips. The assembled
// word is offered on a valid/ready handshake.
module bus_read_sequencer #(
  parameter int NCHIP  = 2,
  parameter int SETTLE = 2
) (
  input  logic               CLK,
  input  logic               RST_,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [7:0]         DBUS,
  output logic [NCHIP-1:0]   OE_,
  output logic               rd_valid,
  input  logic               rd_ready,
  output logic [8*NCHIP-1:0] rd_data,
  output logic               busy
);

  localparam int IW = (NCHIP > 1) ? $clog2(NCHIP) : 1;
  localparam int CW = 4;
  localparam logic [IW-1:0] LAST_IDX = IW'(NCHIP - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_TURN  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [8*NCHIP-1:0] cap_q, cap_d;
  // Enables are registered so they never glitch; they are derived from the
  // next state so they change on the same edge the state does.
  logic [NCHIP-1:0]   oe_q, oe_d;

  // Next-state, counter, capture and enable decode.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    oe_d    = '1;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = S_DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      end
      S_DRIVE: begin
        if (cnt_q == LAST_CNT) begin
          // Last settle cycle: the byte on the bus is now stable.
          for (int i = 0; i < NCHIP; i++) begin
            if (idx_q == IW'(i)) cap_d[8*i +: 8] = DBUS;
          end
          state_d = S_TURN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_TURN: begin
        if (idx_q == LAST_IDX) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          cnt_d   = '0;
          state_d = S_DRIVE;
        end
      end
      S_DONE: begin
        if (rd_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Only the DRIVE state pulls an enable low, and only for the current chip.
    if (state_d == S_DRIVE) begin
      for (int i = 0; i < NCHIP; i++) begin
        if (idx_d == IW'(i)) oe_d[i] = 1'b0;
      end
    end
  end

  // State, counters, capture and enables; reset releases the bus at once.
  always_ff @(posedge CLK or negedge RST_) begin
    if (!RST_) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      cap_q   <= '0;
      oe_q    <= '1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      oe_q    <= oe_d;
    end
  end

  assign OE_       = oe_q;
  assign rd_data   = cap_q;
  assign rd_valid  = (state_q == S_DONE);
  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_bus_read_sequencer.sv
// Directed bench for bus_read_sequencer: default configuration plus a
// four-chip, single-settle instance for the back-to-back sweep.
module tb_bus_read_sequencer;

  logic        CLK = 1'b0;
  logic        RST_;
  logic        req_valid, req_ready, rd_valid, rd_ready, busy;
  logic [7:0]  DBUS;
  logic [1:0]  OE_;
  logic [15:0] rd_data;

  logic        req4, req_ready4, rdv4, busy4;
  logic [7:0]  bus4;
  logic [3:0]  oe4;
  logic [31:0] rdd4;

  logic [7:0]  v0, v1;
  logic [7:0]  vals4 [4];
  logic        settle_mode;
  logic        prev_oe0;

  int checks = 0;
  int errors = 0;

  always #50 CLK = ~CLK;

  bus_read_sequencer #(.NCHIP(2), .SETTLE(2)) dut (
    .CLK(CLK), .RST_(RST_), .req_valid(req_valid), .req_ready(req_ready),
    .DBUS(DBUS), .OE_(OE_), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .rd_data(rd_data), .busy(busy)
  );

  bus_read_sequencer #(.NCHIP(4), .SETTLE(1)) dut4 (
    .CLK(CLK), .RST_(RST_), .req_valid(req4), .req_ready(req_ready4),
    .DBUS(bus4), .OE_(oe4), .rd_valid(rdv4), .rd_ready(1'b1),
    .rd_data(rdd4), .busy(busy4)
  );

  // Remembers whether chip0 was disabled before this edge (first DRIVE cycle).
  always @(posedge CLK) prev_oe0 <= OE_[0];

  // Bus model: the enabled chip drives its byte; idle bus reads as 0xEE.
  always_comb begin
    DBUS = 8'hEE;
    if (!OE_[0]) DBUS = (settle_mode && prev_oe0) ? 8'h00 : v0;
    else if (!OE_[1]) DBUS = v1;
  end

  always_comb begin
    bus4 = 8'hEE;
    for (int i = 0; i < 4; i++) if (!oe4[i]) bus4 = vals4[i];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    while (rd_valid !== 1'b1 && n < 20) begin
      @(negedge CLK);
      n++;
    end
    chk({tag, "_valid"}, 64'(rd_valid), 64'd1);
  endtask

  initial begin
    logic [1:0] exp_oe [6];
    logic [1:0] prev4_lo;
    logic [3:0] prev_oe4;
    logic [31:0] exp_w;
    int txns;
    int n;

    exp_oe = '{2'b10, 2'b10, 2'b11, 2'b01, 2'b01, 2'b11};
    RST_ = 1'b0; req_valid = 1'b0; rd_ready = 1'b1; req4 = 1'b0;
    v0 = 8'h00; v1 = 8'h00; settle_mode = 1'b0;
    for (int i = 0; i < 4; i++) vals4[i] = 8'h00;

    // Reset state
    repeat (2) @(negedge CLK);
    chk("rst_oe", 64'(OE_), 64'h3);
    chk("rst_rd_valid", 64'(rd_valid), 64'h0);
    chk("rst_rd_data", 64'(rd_data), 64'h0);
    chk("rst_req_ready", 64'(req_ready), 64'h1);
    chk("rst_busy", 64'(busy), 64'h0);
    RST_ = 1'b1;
    @(negedge CLK);

    // Basic read with exact enable sequence
    v0 = 8'h5A; v1 = 8'hC3;
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("basic_busy", 64'(busy), 64'h1);
    chk("basic_req_ready", 64'(req_ready), 64'h0);
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("basic_oe%0d", k), 64'(OE_), 64'(exp_oe[k]));
      chk($sformatf("basic_novalid%0d", k), 64'(rd_valid), 64'h0);
      @(negedge CLK);
    end
    chk("basic_rd_valid", 64'(rd_valid), 64'h1);
    chk("basic_rd_data", 64'(rd_data), 64'hC35A);
    chk("basic_done_oe", 64'(OE_), 64'h3);
    @(negedge CLK);
    chk("basic_idle_ready", 64'(req_ready), 64'h1);
    chk("basic_idle_valid", 64'(rd_valid), 64'h0);

    // Settle sampling: chip0 shows 0x00 then 0xFF
    settle_mode = 1'b1; v0 = 8'hFF; v1 = 8'h11;
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    wait_valid("settle");
    chk("settle_byte0", 64'(rd_data[7:0]), 64'hFF);
    chk("settle_byte1", 64'(rd_data[15:8]), 64'h11);
    settle_mode = 1'b0;
    @(negedge CLK);

    // Back-pressure with req_valid held high
    v0 = 8'hA1; v1 = 8'hB2; rd_ready = 1'b0; req_valid = 1'b1;
    @(negedge CLK);
    wait_valid("bp");
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bp_valid%0d", k), 64'(rd_valid), 64'h1);
      chk($sformatf("bp_data%0d", k), 64'(rd_data), 64'hB2A1);
      chk($sformatf("bp_oe%0d", k), 64'(OE_), 64'h3);
      chk($sformatf("bp_req_ready%0d", k), 64'(req_ready), 64'h0);
      @(negedge CLK);
    end
    rd_ready = 1'b1;
    v0 = 8'h0F; v1 = 8'hF0;
    @(negedge CLK);
    chk("bp_release_ready", 64'(req_ready), 64'h1);
    chk("bp_release_valid", 64'(rd_valid), 64'h0);
    @(negedge CLK);
    req_valid = 1'b0;
    chk("bp_next_busy", 64'(busy), 64'h1);
    chk("bp_next_oe", 64'(OE_), 64'h2);
    wait_valid("bp_next");
    chk("bp_next_data", 64'(rd_data), 64'hF00F);
    @(negedge CLK);

    // Request pulsed during busy is ignored
    v0 = 8'h77; v1 = 8'h66;
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    repeat (2) @(negedge CLK);
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    txns = 0;
    for (int k = 0; k < 20; k++) begin
      if (rd_valid === 1'b1) txns++;
      @(negedge CLK);
    end
    chk("busy_req_txns", 64'(txns), 64'd1);
    chk("busy_req_idle", 64'(busy), 64'h0);

    // Asynchronous reset in the middle of DRIVE
    v0 = 8'h99; v1 = 8'h88;
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    chk("arst_pre_oe", 64'(OE_), 64'h2);
    #10 RST_ = 1'b0;
    #1;
    chk("arst_oe", 64'(OE_), 64'h3);
    chk("arst_valid", 64'(rd_valid), 64'h0);
    chk("arst_data", 64'(rd_data), 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    #10 RST_ = 1'b1;
    @(negedge CLK);
    chk("arst_idle", 64'(req_ready), 64'h1);
    v0 = 8'h34; v1 = 8'h12;
    req_valid = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    wait_valid("arst_read");
    chk("arst_read_data", 64'(rd_data), 64'h1234);
    @(negedge CLK);

    // Four-chip back-to-back sweep with random data
    for (int i = 0; i < 4; i++) vals4[i] = 8'($urandom);
    req4 = 1'b1;
    prev_oe4 = 4'hF;
    for (int t = 0; t < 100; t++) begin
      exp_w = {vals4[3], vals4[2], vals4[1], vals4[0]};
      n = 0;
      @(negedge CLK);
      while (rdv4 !== 1'b1 && n < 30) begin
        chk("sweep_excl", 64'($countones(~oe4) <= 1), 64'd1);
        prev4_lo = {(prev_oe4 != 4'hF), (oe4 != 4'hF)};
        chk("sweep_turn", 64'(prev4_lo == 2'b11 && prev_oe4 != oe4), 64'd0);
        prev_oe4 = oe4;
        @(negedge CLK);
        n++;
      end
      chk("sweep_valid", 64'(rdv4), 64'd1);
      chk($sformatf("sweep_data%0d", t), 64'(rdd4), 64'(exp_w));
      prev_oe4 = oe4;
      for (int i = 0; i < 4; i++) vals4[i] = 8'($urandom);
    end
    req4 = 1'b0;
    repeat (3) @(negedge CLK);
    chk("sweep_idle", 64'(busy4), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_read_sequencer.md
# bus_read_sequencer

Read-side controller for the shared 8-bit tri-state data bus in the fixed/erasable memory module. Up to NCHIP dual-nibble tri-state buffer chips drive that bus; each chip's two active-low output enables are tied together and driven by this block. On a request the block enables one chip at a time, waits for the bus to settle, and captures the byte. It inserts a turnaround cycle with all enables high between chips, then presents the assembled word on a valid/ready handshake. The block is the only agent that pulls any buffer enable low, so it also guarantees bus exclusivity.

## Interface
- NCHIP, default 2: number of buffer chips on the bus; legal range 1..8; word width is 8*NCHIP.
- SETTLE, default 2: cycles a chip's enable is held low before its byte is sampled; legal range 1..15.

- CLK  input  1  single clock, rising-edge; period ≥ 100 ns, so the 20 ns buffer delay fits within one cycle.
- RST_  input  1  asynchronous, active-low reset.
- req_valid  input  1  read request.
- req_ready  output  1  high only in IDLE; a request is accepted at an edge where req_valid && req_ready.
- DBUS  input  8  shared tri-state bus; chip bits O0a..O3a map to DBUS[3:0], O0b..O3b to DBUS[7:4].
- OE_  output  NCHIP  active-low enable per chip; OE_[i] drives both OEa_ and OEb_ of chip i.
- rd_valid  output  1  assembled word available.
- rd_ready  input  1  consumer accepts the word.
- rd_data  output  8*NCHIP  assembled word; chip i's byte is at rd_data[8i+7:8i].
- busy  output  1  high in every state except IDLE.

## Operation
- States: IDLE, DRIVE, TURN, DONE. Internal counters: chip index idx (0..NCHIP-1) and settle count cnt (0..SETTLE-1).
- IDLE: OE_ is all ones. On acceptance, set idx=0 and cnt=0 and go to DRIVE. req_valid is ignored in every other state.
- DRIVE: OE_[idx]=0; all other OE_ bits are 1. Increment cnt each cycle.
  - At the edge ending the cycle where cnt==SETTLE-1, register DBUS into byte idx of the capture register and go to TURN.
  - Exactly one OE_ bit is ever low at a time.
- TURN: OE_ is all ones for exactly 1 cycle.
  - If idx==NCHIP-1, go to DONE.
  - Otherwise increment idx, clear cnt and go to DRIVE.
- DONE: rd_valid=1 and rd_data holds the captured word. rd_data is stable while rd_valid=1.
  - On rd_valid && rd_ready, go to IDLE.
  - A req_valid present in the same cycle is not accepted because req_ready=0. It is accepted at the earliest one cycle later.
- Bytes not yet overwritten keep their value from the previous transaction. After a completed transaction every byte is fresh.
- Reset values: state IDLE, OE_ all ones, rd_valid=0, rd_data=0, req_ready=1, busy=0, idx=0, cnt=0.

## Timing
- All outputs are registered or decoded from registered state only. No combinational path runs from any input to any output.
- Acceptance edge is E0. Chip i is enabled from edge E0+i*(SETTLE+1) through E0+i*(SETTLE+1)+SETTLE, with that last edge sampling DBUS.
- rd_valid rises after edge E0+NCHIP*(SETTLE+1).
  - Defaults (NCHIP=2, SETTLE=2): 6 cycles from acceptance to rd_valid.
  - With rd_ready held high, the next request can be accepted at edge E0+8.
- Back-pressure: rd_valid stays high indefinitely while rd_ready=0. No further bus activity occurs in that time.
- Reset mid-operation: when RST_ falls, every OE_ bit goes high immediately, without waiting for CLK, and the capture is discarded. After RST_ rises, the first edge sees state IDLE.
- A single-chip configuration (NCHIP=1) still performs the TURN cycle before DONE.

## Test plan
- Basic read, defaults: chip0 drives 0x5A, chip1 drives 0xC3, rd_ready=1, req pulsed 1 cycle. Required: OE_=2'b10 for 2 cycles, then 2'b11 for 1, then 2'b01 for 2, then 2'b11 for 1; rd_valid rises 6 edges after acceptance with rd_data=0xC35A; returns to IDLE the next edge.
- Settle sampling: chip0 bus value is 0x00 in the first DRIVE cycle and 0xFF in the second, SETTLE=2. Required: captured byte0 is 0xFF.
- Back-pressure: rd_ready=0 for 10 cycles after rd_valid rises, with req_valid held high. Required: rd_valid and rd_data stay constant, OE_ stays all ones, req_ready=0. When rd_ready rises, the handshake completes and the new request is accepted one cycle later.
- Request during busy: req_valid pulsed in the 3rd DRIVE/TURN cycle. Required: ignored; exactly one transaction occurs.
- Async reset mid-DRIVE: assert RST_=0 between clock edges while OE_=2'b10. Required: OE_=2'b11, rd_valid=0, rd_data=0 before the next edge. After release, a new read of 0x1234 completes correctly.
- Exclusivity sweep: NCHIP=4, SETTLE=1, 100 back-to-back reads with random bus data. Required: OE_ never has more than one bit low, a TURN cycle appears between every two enables, and every rd_data matches the driven bytes.
